// File: rtl/obstacle_pkg.sv
// Shared obstacle types: coordinates, indices, bounding box and its empty value.
// Used by the frame buffer, the rasteriser and the collision logic.
package obstacle_pkg;

  localparam int COORD_BITS = 32;
  localparam int MAX_VERTS  = 8;
  localparam int MAX_OBS    = 16;

  typedef logic signed [COORD_BITS-1:0] coord_t;
  typedef logic signed [COORD_BITS:0]   wide_coord_t;
  typedef logic [$clog2(MAX_VERTS)-1:0]   vtx_idx_t;
  typedef logic [$clog2(MAX_OBS)-1:0]     obs_idx_t;
  typedef logic [$clog2(MAX_VERTS+1)-1:0] side_cnt_t;

  typedef struct packed {
    coord_t min_x;
    coord_t max_x;
    coord_t min_y;
    coord_t max_y;
  } bbox_t;

  localparam coord_t COORD_MAX = {1'b0, {(COORD_BITS-1){1'b1}}};
  localparam coord_t COORD_MIN = {1'b1, {(COORD_BITS-1){1'b0}}};

  // Empty box: any real vertex shrinks min and grows max on the first merge.
  localparam bbox_t BBOX_INIT = '{
    min_x: COORD_MAX,
    max_x: COORD_MIN,
    min_y: COORD_MAX,
    max_y: COORD_MIN
  };

  // Sign-extend by one bit so window +/- margin arithmetic cannot wrap.
  function automatic wide_coord_t widen(input coord_t v);
    return {v[COORD_BITS-1], v};
  endfunction

endpackage

// File: rtl/polygon_bbox_tracker.sv
// Running bounding box of the polygon being collected, plus a visibility test
// of the box (including the vertex presented this cycle) against the window.
module polygon_bbox_tracker
  import obstacle_pkg::*;
#(
  parameter int MARGIN = 0
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   i_clear,
  input  logic   i_valid,
  input  coord_t i_x,
  input  coord_t i_y,
  input  coord_t i_win_min_x,
  input  coord_t i_win_max_x,
  input  coord_t i_win_min_y,
  input  coord_t i_win_max_y,
  output logic   o_visible
);

  localparam wide_coord_t W_MARGIN = wide_coord_t'(MARGIN);

  bbox_t       r_box;
  bbox_t       w_merged;
  wide_coord_t w_lim_min_x;
  wide_coord_t w_lim_max_x;
  wide_coord_t w_lim_min_y;
  wide_coord_t w_lim_max_y;

  // Merge the current vertex into the stored box so a commit sees its own final vertex.
  always_comb begin
    w_merged = r_box;
    if (i_valid) begin
      if (i_x < r_box.min_x) w_merged.min_x = i_x;
      if (i_x > r_box.max_x) w_merged.max_x = i_x;
      if (i_y < r_box.min_y) w_merged.min_y = i_y;
      if (i_y > r_box.max_y) w_merged.max_y = i_y;
    end
  end

  // Margin-expanded window and overlap test, one bit wider than the coordinates.
  always_comb begin
    w_lim_min_x = widen(i_win_min_x) - W_MARGIN;
    w_lim_max_x = widen(i_win_max_x) + W_MARGIN;
    w_lim_min_y = widen(i_win_min_y) - W_MARGIN;
    w_lim_max_y = widen(i_win_max_y) + W_MARGIN;
    o_visible = !((widen(w_merged.max_x) < w_lim_min_x) ||
                  (widen(w_merged.min_x) > w_lim_max_x) ||
                  (widen(w_merged.max_y) < w_lim_min_y) ||
                  (widen(w_merged.min_y) > w_lim_max_y));
  end

  // Box register: emptied on reset or when the polygon is committed / frame ends.
  always_ff @(posedge clk_in) begin
    if (!rst_in || i_clear) begin
      r_box <= BBOX_INIT;
    end else if (i_valid) begin
      r_box <= w_merged;
    end
  end

endmodule

// File: rtl/obstacle_frame_buffer.sv
// Per-frame obstacle culler with a double-buffered vertex store. The write bank
// is built from the vertex stream; the renderer reads the other bank.
// WORLD_BITS must match obstacle_pkg::COORD_BITS; vertex/obstacle counts must be
// powers of two so the RAM address is a plain concatenation.
module obstacle_frame_buffer
  import obstacle_pkg::*;
#(
  parameter int WORLD_BITS              = 32,
  parameter int MAX_NUM_VERTICES        = 8,
  parameter int MAX_OBSTACLES_ON_SCREEN = 16,
  parameter int CULL_MARGIN             = 0
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          valid_in,
  input  logic                                          last_in,
  input  logic signed [WORLD_BITS-1:0]                  x_in,
  input  logic signed [WORLD_BITS-1:0]                  y_in,
  input  logic signed [WORLD_BITS-1:0]                  screen_min_x,
  input  logic signed [WORLD_BITS-1:0]                  screen_max_x,
  input  logic signed [WORLD_BITS-1:0]                  screen_min_y,
  input  logic signed [WORLD_BITS-1:0]                  screen_max_y,
  input  logic                                          done_in,
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]    rd_obstacle_in,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]           rd_vertex_in,
  output logic signed [WORLD_BITS-1:0]                  rd_x_out,
  output logic signed [WORLD_BITS-1:0]                  rd_y_out,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]         rd_num_sides_out,
  output logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0]  num_obstacles_out,
  output logic                                          done_out,
  output logic                                          vertex_overflow_out,
  output logic                                          obstacle_overflow_out
);

  localparam int MV    = MAX_NUM_VERTICES;
  localparam int MO    = MAX_OBSTACLES_ON_SCREEN;
  localparam int VW    = $clog2(MV);
  localparam int OW    = $clog2(MO);
  localparam int SW    = $clog2(MV + 1);
  localparam int CW    = $clog2(MO + 1);
  localparam int AW    = 1 + OW + VW;
  localparam int DEPTH = 2 * MO * MV;

  // Frame-building state
  logic          r_wr_bank;
  logic [CW-1:0] r_curr_idx;
  logic [SW-1:0] r_vtx_cnt;
  logic          r_oversize;
  logic          r_vtx_ovf;
  logic          r_obs_ovf;
  logic [SW-1:0] r_num_sides [2][MO];

  // Vertex RAM and its read-side registers
  logic signed [WORLD_BITS-1:0] r_ram_x [DEPTH];
  logic signed [WORLD_BITS-1:0] r_ram_y [DEPTH];
  logic signed [WORLD_BITS-1:0] r_rd_x;
  logic signed [WORLD_BITS-1:0] r_rd_y;
  logic                         r_rd_vtx_ok;

  logic          w_vtx_take;
  logic          w_room;
  logic          w_full;
  logic          w_ram_we;
  logic          w_commit;
  logic          w_oversize;
  logic          w_visible;
  logic          w_keep;
  logic          w_vtx_ovf_set;
  logic          w_obs_ovf_set;
  logic [CW-1:0] w_idx_next;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_bank;
  logic [SW-1:0] w_rd_sides;

  // A vertex arriving without last_in in the done_in cycle belongs to a polygon
  // that is being thrown away, so it is not taken at all.
  assign w_vtx_take    = valid_in && (last_in || !done_in);
  assign w_room        = (r_vtx_cnt != SW'(MV));
  assign w_full        = (r_curr_idx == CW'(MO));
  assign w_ram_we      = w_vtx_take && w_room && !w_full;
  assign w_commit      = valid_in && last_in;
  assign w_oversize    = r_oversize || !w_room;
  assign w_keep        = w_commit && w_visible && !w_oversize && !w_full;
  assign w_vtx_ovf_set = w_commit && w_oversize;
  assign w_obs_ovf_set = w_commit && w_visible && !w_oversize && w_full;
  assign w_idx_next    = r_curr_idx + CW'(w_keep);
  assign w_wr_addr     = {r_wr_bank, r_curr_idx[OW-1:0], r_vtx_cnt[VW-1:0]};
  assign w_rd_bank     = ~r_wr_bank;
  assign w_rd_addr     = {w_rd_bank, rd_obstacle_in, rd_vertex_in};

  // Side counts of slots beyond the published count are stale, so mask them.
  assign w_rd_sides = (CW'(rd_obstacle_in) < num_obstacles_out) ?
                      r_num_sides[w_rd_bank][rd_obstacle_in] : '0;

  polygon_bbox_tracker #(
    .MARGIN (CULL_MARGIN)
  ) u_bbox (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_clear     (w_commit || done_in),
    .i_valid     (w_vtx_take),
    .i_x         (x_in),
    .i_y         (y_in),
    .i_win_min_x (screen_min_x),
    .i_win_max_x (screen_max_x),
    .i_win_min_y (screen_min_y),
    .i_win_max_y (screen_max_y),
    .o_visible   (w_visible)
  );

  // Polygon framing, commit decisions, side-count table and frame publication.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_bank             <= 1'b0;
      r_curr_idx            <= '0;
      r_vtx_cnt             <= '0;
      r_oversize            <= 1'b0;
      r_vtx_ovf             <= 1'b0;
      r_obs_ovf             <= 1'b0;
      num_obstacles_out     <= '0;
      done_out              <= 1'b0;
      vertex_overflow_out   <= 1'b0;
      obstacle_overflow_out <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int o = 0; o < MO; o++) begin
          r_num_sides[b][o] <= '0;
        end
      end
    end else begin
      done_out <= done_in;
      if (w_keep) begin
        r_num_sides[r_wr_bank][r_curr_idx[OW-1:0]] <= r_vtx_cnt + SW'(1);
      end
      if (done_in) begin
        num_obstacles_out     <= w_idx_next;
        vertex_overflow_out   <= r_vtx_ovf || w_vtx_ovf_set;
        obstacle_overflow_out <= r_obs_ovf || w_obs_ovf_set;
        r_wr_bank             <= ~r_wr_bank;
        r_curr_idx            <= '0;
        r_vtx_ovf             <= 1'b0;
        r_obs_ovf             <= 1'b0;
        r_vtx_cnt             <= '0;
        r_oversize            <= 1'b0;
      end else begin
        r_curr_idx <= w_idx_next;
        r_vtx_ovf  <= r_vtx_ovf || w_vtx_ovf_set;
        r_obs_ovf  <= r_obs_ovf || w_obs_ovf_set;
        if (w_commit) begin
          r_vtx_cnt  <= '0;
          r_oversize <= 1'b0;
        end else if (w_vtx_take) begin
          if (w_room) r_vtx_cnt <= r_vtx_cnt + SW'(1);
          else        r_oversize <= 1'b1;
        end
      end
    end
  end

  // Vertex RAM: write into the build bank, registered read from the other bank.
  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      r_ram_x[w_wr_addr] <= x_in;
      r_ram_y[w_wr_addr] <= y_in;
    end
    r_rd_x <= r_ram_x[w_rd_addr];
    r_rd_y <= r_ram_y[w_rd_addr];
  end

  // Read-side qualifiers registered alongside the RAM data.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_num_sides_out <= '0;
      r_rd_vtx_ok      <= 1'b0;
    end else begin
      rd_num_sides_out <= w_rd_sides;
      r_rd_vtx_ok      <= (SW'(rd_vertex_in) < w_rd_sides);
    end
  end

  assign rd_x_out = r_rd_vtx_ok ? r_rd_x : '0;
  assign rd_y_out = r_rd_vtx_ok ? r_rd_y : '0;

endmodule

// File: tb/tb_obstacle_frame_buffer.sv
// Directed bench for obstacle_frame_buffer: a margin-0 and a margin-20 instance
// share all inputs; expected values are hand-computed per scenario.
module tb_obstacle_frame_buffer;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               valid_in;
  logic               last_in;
  logic signed [31:0] x_in, y_in;
  logic signed [31:0] screen_min_x, screen_max_x, screen_min_y, screen_max_y;
  logic               done_in;
  logic [3:0]         rd_obstacle_in;
  logic [2:0]         rd_vertex_in;

  logic signed [31:0] rd_x, rd_y, rd_x_m, rd_y_m;
  logic [3:0]         rd_sides, rd_sides_m;
  logic [4:0]         num_obs, num_obs_m;
  logic               done_o, done_o_m, vovf, vovf_m, oovf, oovf_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  obstacle_frame_buffer #(
    .WORLD_BITS(32), .MAX_NUM_VERTICES(8), .MAX_OBSTACLES_ON_SCREEN(16), .CULL_MARGIN(0)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .last_in(last_in),
    .x_in(x_in), .y_in(y_in),
    .screen_min_x(screen_min_x), .screen_max_x(screen_max_x),
    .screen_min_y(screen_min_y), .screen_max_y(screen_max_y),
    .done_in(done_in), .rd_obstacle_in(rd_obstacle_in), .rd_vertex_in(rd_vertex_in),
    .rd_x_out(rd_x), .rd_y_out(rd_y), .rd_num_sides_out(rd_sides),
    .num_obstacles_out(num_obs), .done_out(done_o),
    .vertex_overflow_out(vovf), .obstacle_overflow_out(oovf)
  );

  obstacle_frame_buffer #(
    .WORLD_BITS(32), .MAX_NUM_VERTICES(8), .MAX_OBSTACLES_ON_SCREEN(16), .CULL_MARGIN(20)
  ) dut_m (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .last_in(last_in),
    .x_in(x_in), .y_in(y_in),
    .screen_min_x(screen_min_x), .screen_max_x(screen_max_x),
    .screen_min_y(screen_min_y), .screen_max_y(screen_max_y),
    .done_in(done_in), .rd_obstacle_in(rd_obstacle_in), .rd_vertex_in(rd_vertex_in),
    .rd_x_out(rd_x_m), .rd_y_out(rd_y_m), .rd_num_sides_out(rd_sides_m),
    .num_obstacles_out(num_obs_m), .done_out(done_o_m),
    .vertex_overflow_out(vovf_m), .obstacle_overflow_out(oovf_m)
  );

  // Advance one clock; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic vtx(input int x, input int y, input bit last);
    valid_in = 1'b1; last_in = last; x_in = x; y_in = y;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic frame_end();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic rd(input int o, input int v);
    rd_obstacle_in = 4'(o); rd_vertex_in = 3'(v);
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick(); tick();
    n_checks++; if (num_obs !== 5'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", num_obs); end
    n_checks++; if ({done_o, vovf, oovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {done_o, vovf, oovf}); end
    n_checks++; if (rd_sides !== 4'd0 || rd_x !== 0 || rd_y !== 0) begin n_fail++; $display("FAIL reset_read got %0d/%0d/%0d want 0/0/0", rd_sides, rd_x, rd_y); end
    rst_in = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    vtx(10, 10, 0); vtx(50, 10, 0); vtx(30, 40, 1);
    frame_end();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done_pulse got %b want 1", done_o); end
    n_checks++; if (num_obs !== 5'd1) begin n_fail++; $display("FAIL basic_num got %0d want 1", num_obs); end
    n_checks++; if ({vovf, oovf} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", {vovf, oovf}); end
    rd(0, 2);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", done_o); end
    n_checks++; if (rd_sides !== 4'd3) begin n_fail++; $display("FAIL basic_sides got %0d want 3", rd_sides); end
    n_checks++; if (rd_x !== 30 || rd_y !== 40) begin n_fail++; $display("FAIL basic_v2 got (%0d,%0d) want (30,40)", rd_x, rd_y); end
    rd(0, 3);
    n_checks++; if (rd_x !== 0 || rd_y !== 0) begin n_fail++; $display("FAIL basic_vtx_oob got (%0d,%0d) want (0,0)", rd_x, rd_y); end
    rd(1, 0);
    n_checks++; if (rd_sides !== 4'd0 || rd_x !== 0) begin n_fail++; $display("FAIL basic_obs_oob got %0d/%0d want 0/0", rd_sides, rd_x); end
    $display("test_basic done");
  endtask

  task automatic test_cull_margin();
    vtx(650, 10, 0); vtx(700, 10, 0); vtx(700, 50, 0); vtx(650, 50, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd0) begin n_fail++; $display("FAIL cull_m0 got %0d want 0", num_obs); end
    n_checks++; if (num_obs_m !== 5'd1) begin n_fail++; $display("FAIL cull_m20 got %0d want 1", num_obs_m); end
    vtx(32'sh8000_0000, 10, 0); vtx(32'sh8000_0000, 20, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd0 || num_obs_m !== 5'd0) begin n_fail++; $display("FAIL cull_minint got %0d/%0d want 0/0", num_obs, num_obs_m); end
    // Window edge near the most-negative value: margin subtraction must not wrap.
    screen_min_x = -32'sd2147483638;
    vtx(-2147483643, 10, 0); vtx(-2147483643, 20, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd0) begin n_fail++; $display("FAIL cull_wrap_m0 got %0d want 0", num_obs); end
    n_checks++; if (num_obs_m !== 5'd1) begin n_fail++; $display("FAIL cull_wrap_m20 got %0d want 1", num_obs_m); end
    screen_min_x = 0;
    $display("test_cull_margin done");
  endtask

  task automatic test_vertex_overflow();
    for (int i = 0; i < 9; i++) vtx(100 + i, 100, (i == 8));
    vtx(1, 1, 0); vtx(5, 1, 0); vtx(5, 5, 0); vtx(1, 5, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd1) begin n_fail++; $display("FAIL vovf_num got %0d want 1", num_obs); end
    n_checks++; if ({vovf, oovf} !== 2'b10) begin n_fail++; $display("FAIL vovf_flags got %b want 10", {vovf, oovf}); end
    rd(0, 3);
    n_checks++; if (rd_sides !== 4'd4) begin n_fail++; $display("FAIL vovf_sides got %0d want 4", rd_sides); end
    n_checks++; if (rd_x !== 1 || rd_y !== 5) begin n_fail++; $display("FAIL vovf_v3 got (%0d,%0d) want (1,5)", rd_x, rd_y); end
    // Exactly MAX_NUM_VERTICES vertices is still a legal polygon.
    for (int i = 0; i < 8; i++) vtx(200 + i, 150 + i, (i == 7));
    frame_end();
    n_checks++; if (num_obs !== 5'd1 || vovf !== 1'b0) begin n_fail++; $display("FAIL v8_frame got %0d/%b want 1/0", num_obs, vovf); end
    rd(0, 7);
    n_checks++; if (rd_sides !== 4'd8 || rd_x !== 207 || rd_y !== 157) begin n_fail++; $display("FAIL v8_read got %0d (%0d,%0d) want 8 (207,157)", rd_sides, rd_x, rd_y); end
    $display("test_vertex_overflow done");
  endtask

  task automatic test_obstacle_overflow();
    for (int i = 0; i < 17; i++) begin
      vtx(i, 0, 0); vtx(i + 1, 0, 0); vtx(i, 1, 1);
    end
    frame_end();
    n_checks++; if (num_obs !== 5'd16) begin n_fail++; $display("FAIL oovf_num got %0d want 16", num_obs); end
    n_checks++; if ({vovf, oovf} !== 2'b01) begin n_fail++; $display("FAIL oovf_flags got %b want 01", {vovf, oovf}); end
    rd(15, 0);
    n_checks++; if (rd_x !== 15 || rd_sides !== 4'd3) begin n_fail++; $display("FAIL oovf_last got %0d/%0d want 15/3", rd_x, rd_sides); end
    rd(0, 1);
    n_checks++; if (rd_x !== 1 || rd_y !== 0) begin n_fail++; $display("FAIL oovf_first got (%0d,%0d) want (1,0)", rd_x, rd_y); end
    vtx(20, 20, 0); vtx(30, 20, 0); vtx(25, 30, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd1 || {vovf, oovf} !== 2'b00) begin n_fail++; $display("FAIL clean_frame got %0d/%b want 1/00", num_obs, {vovf, oovf}); end
    $display("test_obstacle_overflow done");
  endtask

  task automatic test_double_buffer();
    vtx(100, 100, 0); vtx(200, 100, 0); vtx(150, 200, 1);
    frame_end();
    vtx(300, 300, 0); vtx(400, 300, 0);
    rd(0, 0);
    n_checks++; if (rd_x !== 100 || rd_y !== 100 || rd_sides !== 4'd3) begin n_fail++; $display("FAIL db_read_while_build got (%0d,%0d) %0d want (100,100) 3", rd_x, rd_y, rd_sides); end
    vtx(400, 400, 0); vtx(300, 400, 1);
    vtx(10, 20, 0); vtx(30, 20, 0);
    // Final vertex, frame end and a read all in the same cycle.
    valid_in = 1'b1; last_in = 1'b1; x_in = 20; y_in = 40; done_in = 1'b1;
    rd_obstacle_in = 4'd0; rd_vertex_in = 3'd1;
    tick();
    valid_in = 1'b0; last_in = 1'b0; done_in = 1'b0;
    n_checks++; if (num_obs !== 5'd2) begin n_fail++; $display("FAIL db_same_cycle_commit got %0d want 2", num_obs); end
    n_checks++; if (rd_x !== 200 || rd_y !== 100) begin n_fail++; $display("FAIL db_read_at_done got (%0d,%0d) want (200,100)", rd_x, rd_y); end
    rd(1, 2);
    n_checks++; if (rd_x !== 20 || rd_y !== 40 || rd_sides !== 4'd3) begin n_fail++; $display("FAIL db_obs1 got (%0d,%0d) %0d want (20,40) 3", rd_x, rd_y, rd_sides); end
    rd(0, 3);
    n_checks++; if (rd_x !== 300 || rd_y !== 400 || rd_sides !== 4'd4) begin n_fail++; $display("FAIL db_obs0 got (%0d,%0d) %0d want (300,400) 4", rd_x, rd_y, rd_sides); end
    vtx(5, 5, 0); vtx(6, 5, 0); vtx(5, 6, 1);
    vtx(7, 7, 0); vtx(8, 8, 0);
    valid_in = 1'b1; last_in = 1'b0; x_in = 9; y_in = 9; done_in = 1'b1;
    tick();
    valid_in = 1'b0; done_in = 1'b0;
    n_checks++; if (num_obs !== 5'd1 || vovf !== 1'b0) begin n_fail++; $display("FAIL db_open_poly got %0d/%b want 1/0", num_obs, vovf); end
    vtx(50, 50, 0); vtx(60, 50, 0); vtx(55, 60, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd1) begin n_fail++; $display("FAIL db_after_open got %0d want 1", num_obs); end
    rd(0, 0);
    n_checks++; if (rd_x !== 50 || rd_y !== 50 || rd_sides !== 4'd3) begin n_fail++; $display("FAIL db_after_open_v0 got (%0d,%0d) %0d want (50,50) 3", rd_x, rd_y, rd_sides); end
    rd(0, 2);
    n_checks++; if (rd_x !== 55 || rd_y !== 60) begin n_fail++; $display("FAIL db_after_open_v2 got (%0d,%0d) want (55,60)", rd_x, rd_y); end
    $display("test_double_buffer done");
  endtask

  task automatic test_reset_mid_polygon();
    vtx(1, 2, 0); vtx(3, 4, 0);
    rst_in = 1'b0; rd_obstacle_in = 4'd0; rd_vertex_in = 3'd0;
    tick();
    rst_in = 1'b1;
    n_checks++; if (num_obs !== 5'd0 || {done_o, vovf, oovf} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outputs got %0d/%b want 0/000", num_obs, {done_o, vovf, oovf}); end
    n_checks++; if (rd_sides !== 4'd0 || rd_x !== 0 || rd_y !== 0) begin n_fail++; $display("FAIL rstmid_read got %0d (%0d,%0d) want 0 (0,0)", rd_sides, rd_x, rd_y); end
    vtx(70, 80, 0); vtx(90, 80, 0); vtx(80, 95, 1);
    frame_end();
    n_checks++; if (num_obs !== 5'd1) begin n_fail++; $display("FAIL rstmid_num got %0d want 1", num_obs); end
    rd(0, 0);
    n_checks++; if (rd_x !== 70 || rd_y !== 80 || rd_sides !== 4'd3) begin n_fail++; $display("FAIL rstmid_v0 got (%0d,%0d) %0d want (70,80) 3", rd_x, rd_y, rd_sides); end
    rd(0, 1);
    n_checks++; if (rd_x !== 90 || rd_y !== 80) begin n_fail++; $display("FAIL rstmid_v1 got (%0d,%0d) want (90,80)", rd_x, rd_y); end
    rd(0, 2);
    n_checks++; if (rd_x !== 80 || rd_y !== 95) begin n_fail++; $display("FAIL rstmid_v2 got (%0d,%0d) want (80,95)", rd_x, rd_y); end
    $display("test_reset_mid_polygon done");
  endtask

  initial begin
    rst_in = 1'b0; valid_in = 1'b0; last_in = 1'b0; done_in = 1'b0;
    x_in = 0; y_in = 0;
    screen_min_x = 0; screen_max_x = 640; screen_min_y = 0; screen_max_y = 480;
    rd_obstacle_in = 4'd0; rd_vertex_in = 3'd0;
    test_reset();
    test_basic();
    test_cull_margin();
    test_vertex_overflow();
    test_obstacle_overflow();
    test_double_buffer();
    test_reset_mid_polygon();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
